// File: rtl/regfile_sched_pkg.sv
// Shared constants, types and helpers for the LC-3 operand scheduler.
package regfile_sched_pkg;

    localparam int unsigned NREGS      = 8;
    localparam int unsigned AW         = 3;
    localparam int unsigned DW         = 16;
    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned SW         = $clog2(STARVE_MAX + 1);

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    typedef enum logic [1:0] {
        WSEL_NONE = 2'd0,
        WSEL_ALU  = 2'd1,
        WSEL_MEM  = 2'd2
    } wsel_t;

    // One-hot register mask for a register address.
    function automatic logic [NREGS-1:0] reg_mask(input reg_addr_t a);
        return NREGS'(1) << a;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: ALU has fixed priority, mem is forced a grant after
// STARVE_MAX consecutive lost cycles.
module regfile_wr_arb
    import regfile_sched_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  alu_wvalid,
    input  logic  mem_wvalid,
    output wsel_t grant,
    output logic  alu_wready,
    output logic  mem_wready
);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == SW'(STARVE_MAX));

    // Grant selection: single requester wins; on conflict ALU unless mem is starved.
    always_comb begin
        grant = WSEL_NONE;
        if (alu_wvalid && mem_wvalid) begin
            grant = starved ? WSEL_MEM : WSEL_ALU;
        end else if (alu_wvalid) begin
            grant = WSEL_ALU;
        end else if (mem_wvalid) begin
            grant = WSEL_MEM;
        end
    end

    assign alu_wready = (grant == WSEL_ALU);
    assign mem_wready = (grant == WSEL_MEM);

    // Starve counter: counts mem's lost cycles, saturating; clears on mem grant or idle mem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!mem_wvalid || mem_wready) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/regfile_sched.sv
// Operand scheduler for the LC-3 8x16 register file: busy scoreboard,
// RAW/WAW stall, read-port drive and write-port arbitration.
// Optional forwarding of the same-cycle write: define REGFILE_SCHED_BYPASS_EN.
module regfile_sched
    import regfile_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [AW-1:0]    dec_src0,
    input  logic [AW-1:0]    dec_src1,
    input  logic [AW-1:0]    dec_dst,
    input  logic             dec_src0_en,
    input  logic             dec_src1_en,
    input  logic             dec_dst_en,
    output logic             op_valid,
    output logic [DW-1:0]    op_data0,
    output logic [DW-1:0]    op_data1,
    input  logic             alu_wvalid,
    output logic             alu_wready,
    input  logic [AW-1:0]    alu_waddr,
    input  logic [DW-1:0]    alu_wdata,
    input  logic             mem_wvalid,
    output logic             mem_wready,
    input  logic [AW-1:0]    mem_waddr,
    input  logic [DW-1:0]    mem_wdata,
    output logic             rf_ren0,
    output logic             rf_ren1,
    output logic [AW-1:0]    rf_raddr0,
    output logic [AW-1:0]    rf_raddr1,
    input  logic [DW-1:0]    rf_rdata0,
    input  logic [DW-1:0]    rf_rdata1,
    output logic             rf_wen,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [NREGS-1:0] busy
);

    wsel_t            wsel;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] busy_chk;
    logic             hazard;
    logic             accept;
    logic             en0_q;
    logic             en1_q;
    word_t            rd0;
    word_t            rd1;

    regfile_wr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .alu_wvalid (alu_wvalid),
        .mem_wvalid (mem_wvalid),
        .grant      (wsel),
        .alu_wready (alu_wready),
        .mem_wready (mem_wready)
    );

    // Write-port mux driven by the granted writer.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (wsel)
            WSEL_ALU: begin
                rf_wen   = 1'b1;
                rf_waddr = alu_waddr;
                rf_wdata = alu_wdata;
            end
            WSEL_MEM: begin
                rf_wen   = 1'b1;
                rf_waddr = mem_waddr;
                rf_wdata = mem_wdata;
            end
            default: ;
        endcase
    end

    assign clr_vec = rf_wen ? reg_mask(rf_waddr) : '0;

`ifdef REGFILE_SCHED_BYPASS_EN
    // A register being written this cycle no longer blocks decode.
    assign busy_chk = busy & ~clr_vec;
`else
    assign busy_chk = busy;
`endif

    assign hazard = (dec_src0_en & busy_chk[dec_src0]) |
                    (dec_src1_en & busy_chk[dec_src1]) |
                    (dec_dst_en  & busy_chk[dec_dst]);

    assign dec_ready = !hazard;
    assign accept    = dec_valid & dec_ready;

    assign rf_ren0   = accept & dec_src0_en;
    assign rf_ren1   = accept & dec_src1_en;
    assign rf_raddr0 = dec_src0;
    assign rf_raddr1 = dec_src1;

    assign set_vec = (accept && dec_dst_en) ? reg_mask(dec_dst) : '0;

    // Scoreboard update; a new producer's set overrides a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

    // Operand-return pipeline stage aligned with the register-file read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
            en0_q    <= 1'b0;
            en1_q    <= 1'b0;
        end else begin
            op_valid <= accept;
            en0_q    <= rf_ren0;
            en1_q    <= rf_ren1;
        end
    end

`ifdef REGFILE_SCHED_BYPASS_EN
    logic  byp0_q;
    logic  byp1_q;
    word_t wdata_q;

    // Capture the write data for sources read in the same cycle as their write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp0_q  <= 1'b0;
            byp1_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            byp0_q  <= rf_ren0 & rf_wen & (rf_waddr == dec_src0);
            byp1_q  <= rf_ren1 & rf_wen & (rf_waddr == dec_src1);
            wdata_q <= rf_wdata;
        end
    end

    assign rd0 = byp0_q ? wdata_q : rf_rdata0;
    assign rd1 = byp1_q ? wdata_q : rf_rdata1;
`else
    assign rd0 = rf_rdata0;
    assign rd1 = rf_rdata1;
`endif

    assign op_data0 = (op_valid && en0_q) ? rd0 : '0;
    assign op_data1 = (op_valid && en1_q) ? rd1 : '0;

endmodule

// File: tb/tb_regfile_sched.sv
// Directed scoreboard bench for regfile_sched with a behavioural register file.
module tb_regfile_sched;
    import regfile_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid, dec_ready;
    logic [AW-1:0]    dec_src0, dec_src1, dec_dst;
    logic             dec_src0_en, dec_src1_en, dec_dst_en;
    logic             op_valid;
    logic [DW-1:0]    op_data0, op_data1;
    logic             alu_wvalid, alu_wready;
    logic [AW-1:0]    alu_waddr;
    logic [DW-1:0]    alu_wdata;
    logic             mem_wvalid, mem_wready;
    logic [AW-1:0]    mem_waddr;
    logic [DW-1:0]    mem_wdata;
    logic             rf_ren0, rf_ren1;
    logic [AW-1:0]    rf_raddr0, rf_raddr1;
    logic [DW-1:0]    rf_rdata0, rf_rdata1;
    logic             rf_wen;
    logic [AW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [NREGS-1:0] busy;

    typedef struct packed {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t          expq[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] rfm [NREGS];

    always #5 clk = ~clk;

    regfile_sched dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_src0(dec_src0), .dec_src1(dec_src1), .dec_dst(dec_dst),
        .dec_src0_en(dec_src0_en), .dec_src1_en(dec_src1_en), .dec_dst_en(dec_dst_en),
        .op_valid(op_valid), .op_data0(op_data0), .op_data1(op_data1),
        .alu_wvalid(alu_wvalid), .alu_wready(alu_wready),
        .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .rf_ren0(rf_ren0), .rf_ren1(rf_ren1),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
        .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy)
    );

    // Register file model: registered reads (old data on same-cycle write).
    always @(posedge clk) begin
        if (rf_wen) rfm[rf_waddr] <= rf_wdata;
        if (rf_ren0) rf_rdata0 <= rfm[rf_raddr0];
        if (rf_ren1) rf_rdata1 <= rfm[rf_raddr1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every operand return is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst && op_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL op_unexpected: got d0=0x%0h d1=0x%0h expected no operand", op_data0, op_data1);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (op_data0 !== e.d0 || op_data1 !== e.d1) begin
                    errors++;
                    $display("FAIL op_data: got d0=0x%0h d1=0x%0h expected d0=0x%0h d1=0x%0h",
                             op_data0, op_data1, e.d0, e.d1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [AW-1:0] s0, input logic e0,
                       input logic [AW-1:0] s1, input logic e1,
                       input logic [AW-1:0] d, input logic ed);
        dec_valid = v; dec_src0 = s0; dec_src0_en = e0;
        dec_src1 = s1; dec_src1_en = e1; dec_dst = d; dec_dst_en = ed;
    endtask

    task automatic push(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        exp_t e;
        e.d0 = d0;
        e.d1 = d1;
        expq.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < int'(NREGS); i++) rfm[i] = DW'(16'h0101 * i);
        rst = 1'b1;
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        alu_wvalid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        mem_wvalid = 1'b0; mem_waddr = '0; mem_wdata = '0;
        repeat (3) step();
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_op_valid", 32'(op_valid), 32'h0);
        rst = 1'b0;
        step();

        // Basic issue: R1, R2 -> R3
        dec(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1);
        #1;
        check("issue_ready", 32'(dec_ready), 32'h1);
        check("issue_raddr0", 32'({rf_ren0, rf_raddr0}), 32'({1'b1, 3'd1}));
        push(16'h0101, 16'h0202);
        step();
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        check("issue_busy", 32'(busy), 32'h08);
        step();

        // RAW on R3
        dec(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        #1;
        check("raw_stall0", 32'(dec_ready), 32'h0);
        step();
        check("raw_stall1", 32'(dec_ready), 32'h0);
        alu_wvalid = 1'b1; alu_waddr = 3'd3; alu_wdata = 16'h1234;
        #1;
        check("raw_alu_grant", 32'({alu_wready, rf_wen, rf_waddr}), 32'({1'b1, 1'b1, 3'd3}));
`ifdef REGFILE_SCHED_BYPASS_EN
        check("raw_ready_write_cycle", 32'(dec_ready), 32'h1);
        push(16'h1234, 16'h0000);
        step();
        alu_wvalid = 1'b0;
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
`else
        check("raw_ready_write_cycle", 32'(dec_ready), 32'h0);
        step();
        alu_wvalid = 1'b0;
        #1;
        check("raw_ready_after", 32'(dec_ready), 32'h1);
        push(16'h1234, 16'h0000);
        step();
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
`endif
        check("raw_busy", 32'(busy), 32'h0);
        step();

        // WAW on R5
        dec(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
        push(16'h0, 16'h0);
        step();
        check("waw_busy_set", 32'(busy), 32'h20);
        #1;
        check("waw_stall", 32'(dec_ready), 32'h0);
        step();
        mem_wvalid = 1'b1; mem_waddr = 3'd5; mem_wdata = 16'hBEEF;
        #1;
        check("waw_mem_grant", 32'({mem_wready, rf_waddr}), 32'({1'b1, 3'd5}));
`ifdef REGFILE_SCHED_BYPASS_EN
        check("waw_ready_write_cycle", 32'(dec_ready), 32'h1);
        push(16'h0, 16'h0);
        step();
        mem_wvalid = 1'b0;
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
`else
        check("waw_ready_write_cycle", 32'(dec_ready), 32'h0);
        step();
        mem_wvalid = 1'b0;
        #1;
        check("waw_ready_after", 32'(dec_ready), 32'h1);
        push(16'h0, 16'h0);
        step();
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
`endif
        check("waw_busy_after", 32'(busy), 32'h20);
        alu_wvalid = 1'b1; alu_waddr = 3'd5; alu_wdata = 16'h5555;
        step();
        alu_wvalid = 1'b0;
        check("waw_busy_clear", 32'(busy), 32'h0);

        // Starvation guard: both writers valid continuously
        alu_wvalid = 1'b1; alu_waddr = 3'd0; alu_wdata = 16'hA0A0;
        mem_wvalid = 1'b1; mem_waddr = 3'd1; mem_wdata = 16'hB1B1;
        for (int c = 0; c < 5; c++) begin
            logic exp_mem;
            exp_mem = (c == 3);
            #1;
            check($sformatf("starve_c%0d", c), 32'({alu_wready, mem_wready, rf_waddr}),
                  32'({~exp_mem, exp_mem, exp_mem ? 3'd1 : 3'd0}));
            step();
        end
        alu_wvalid = 1'b0; mem_wvalid = 1'b0;
        check("starve_busy", 32'(busy), 32'h0);

        // Set beats clear on R2
        alu_wvalid = 1'b1; alu_waddr = 3'd2; alu_wdata = 16'h2222;
        dec(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        #1;
        check("setclr_ready", 32'(dec_ready), 32'h1);
        push(16'h0, 16'h0);
        step();
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        alu_wvalid = 1'b0;
        check("setclr_busy", 32'(busy), 32'h04);
        alu_wvalid = 1'b1;
        step();
        alu_wvalid = 1'b0;
        check("setclr_busy_clear", 32'(busy), 32'h0);

        // Reset mid-operation drops the in-flight operand immediately
        dec(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1);
        step();
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        check("midrst_pre", 32'({op_valid, busy}), 32'({1'b1, 8'h10}));
        rst = 1'b1;
        #1;
        check("midrst_op_valid", 32'(op_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_op_data", 32'(op_data0), 32'h0);
        step();
        rst = 1'b0;
        step();
        step();
        check("queue_drained", 32'(expq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sched.md
# regfile_sched

Operand scheduler for the LC-3 8×16 register file. Sits between decode and the two-read/one-write register file. Keeps a per-register busy scoreboard and stalls decode on read-after-write and write-after-write hazards. Drives both read ports and returns operands one cycle later. Arbitrates the single write port between ALU and memory-load writeback, with a starvation guard.

## Interface
- NREGS, 8, number of architectural registers
- AW, 3, register address width
- DW, 16, data width
- STARVE_MAX, 3, consecutive lost cycles after which the mem writer is forced a grant
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- dec_valid / dec_ready  in / out  1  decode issue handshake
- dec_src0, dec_src1, dec_dst  in  AW  source and destination register addresses
- dec_src0_en, dec_src1_en, dec_dst_en  in  1  per-field enables
- op_valid  out  1  operands valid (one-cycle pulse)
- op_data0, op_data1  out  DW  operand values
- alu_wvalid / alu_wready  in / out  1  ALU writeback handshake
- alu_waddr, alu_wdata  in  AW / DW  ALU writeback address and data
- mem_wvalid / mem_wready  in / out  1  load writeback handshake
- mem_waddr, mem_wdata  in  AW / DW  load writeback address and data
- rf_ren0, rf_ren1  out  1  register-file read enables
- rf_raddr0, rf_raddr1  out  AW  register-file read addresses
- rf_rdata0, rf_rdata1  in  DW  register-file read data (registered, 1-cycle latency)
- rf_wen  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- busy  out  NREGS  scoreboard, bit i set = register i has a pending write

## Operation
- **Hazard:** raised if any enabled field names a set busy bit (src: RAW, dst: WAW).
- **Decode handshake:**
  - dec_ready = !hazard; it does not depend on dec_valid.
  - Accept = dec_valid & dec_ready.
- **On accept (cycle N):**
  - rf_renK = dec_srcK_en; rf_raddrK = dec_srcK (combinational).
  - If dec_dst_en, busy[dec_dst] sets at the end of N.
- **Operand return:**
  - op_valid registers the accept.
  - op_dataK = rf_rdataK during the op_valid cycle; value is 0 for a disabled source.
  - No backpressure on the operand output.
- **Write arbitration:**
  - Single requester is granted.
  - Both valid: ALU wins unless the starve counter == STARVE_MAX, then mem wins.
  - Starve counter increments on each cycle mem_wvalid loses; clears on a mem grant or when mem_wvalid is low; saturates at STARVE_MAX.
  - Granted writer drives rf_wen/rf_waddr/rf_wdata combinationally; its wready = 1.
  - busy[waddr] clears at the end of the grant cycle.
  - A write to a non-busy register is legal; busy stays 0.
- **Same-register set and clear in one cycle:** set wins (the new producer owns the register).
- **Reset:** busy=0, op_valid=0, starve counter=0, op_data=0. An in-flight op_valid is dropped.

## Timing
- Decode accept N → op_valid at N+1.
- Issue throughput: 1 per cycle when hazard-free.
- Write grant in the same cycle as wvalid. Cleared busy is visible to hazard checks at N+1.
- Without bypass, a dependent decode stalls through the producer's write cycle and is accepted at the earliest cycle after it. The register file has already stored the new value by then.
- Max mem-writeback wait under continuous ALU traffic: STARVE_MAX+1 cycles.

## Configuration
- REGFILE_SCHED_BYPASS_EN defined:
  - A source whose busy bit is being cleared by this cycle's write grant is not a hazard, so decode is accepted in the write cycle.
  - A registered per-source select makes op_dataK come from captured rf_wdata instead of rf_rdataK. The register file returns stale data for same-cycle read/write.
  - A WAW hazard against a register cleared in the same cycle is also waived.
- Undefined: no forwarding path; hazards are evaluated strictly on registered busy.

## Structure
- Package regfile_sched_pkg holds:
  - constants NREGS, AW, DW, STARVE_MAX;
  - typedefs reg_addr_t [AW-1:0], word_t [DW-1:0];
  - typedef wsel_t {WSEL_NONE, WSEL_ALU, WSEL_MEM}.
- Sub-module regfile_wr_arb holds the two-requester fixed-priority arbiter with the starvation counter. It outputs grant select and both wready signals.

## Test plan
- **Reset clears state:** reset, then decode src0=R1, src1=R2, dst=R3 → accepted; op_valid next cycle with register contents; busy=8'b0000_1000.
- **RAW stall:**
  - Stimulus: busy[3] set; decode src0=R3.
  - Response: dec_ready=0 until an ALU write to R3 with 0x1234. Without bypass, accepted the cycle after the write and op_data0=0x1234. With bypass, accepted in the write cycle and op_data0=0x1234.
- **WAW stall:** busy[5] set; decode dst=R5 → stalled; mem write to R5 → decode accepted next cycle; busy[5]=1.
- **Starvation guard:** ALU and mem both valid every cycle → ALU granted 3 cycles, mem granted on the 4th, counter back to 0.
- **Set beats clear:** write grant to R2 in the same cycle as decode accept with dst=R2 → busy[2]=1 afterwards.
- **Reset mid-operation:** rst asserted in the cycle after accept → op_valid=0 and busy=0 immediately, without waiting for a clock edge.
